// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC request sequencer
// and its quadrant-correction helper.
package cordic_pkg;
    localparam int W      = 16;
    localparam int ITERS  = 16;
    localparam int ADDR_W = $clog2(ITERS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        CAPT,
        DONE
    } cordic_seq_state_t;

    localparam logic [W-1:0] ANG_90  = 16'h4000;
    localparam logic [W-1:0] ANG_180 = 16'h8000;
    localparam logic [W-1:0] ONE_Q14 = 16'h4000;
    localparam logic [W-1:0] MAX_POS = 16'h7FFF;
endpackage

// File: rtl/cordic16_seq_if.sv
// Request/result handshakes plus the core-facing load/addr/endangle bundle.
interface cordic16_seq_if import cordic_pkg::*; ();
    logic                     in_valid;
    logic                     in_ready;
    logic        [W-1:0]      in_angle;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [W-1:0]      out_sin;
    logic signed [W-1:0]      out_cos;
    logic                     busy;
    logic                     load;
    logic        [ADDR_W-1:0] addr;
    logic        [W-1:0]      endangle;
    logic signed [W-1:0]      core_sin;
    logic signed [W-1:0]      core_cos;

    modport slave (
        input  in_valid, in_angle, out_ready, core_sin, core_cos,
        output in_ready, out_valid, out_sin, out_cos, busy, load, addr, endangle
    );

    modport master (
        output in_valid, in_angle, out_ready, core_sin, core_cos,
        input  in_ready, out_valid, out_sin, out_cos, busy, load, addr, endangle
    );
endinterface

// File: rtl/cordic_quadfix.sv
// Conditional negate used to undo the 180-degree fold; -0x8000 saturates.
module cordic_quadfix import cordic_pkg::*; (
    input  logic                neg_i,
    input  logic signed [W-1:0] val_i,
    output logic signed [W-1:0] val_o
);
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        if (v == $signed(~MAX_POS)) return $signed(MAX_POS);
        return -v;
    endfunction

    always_comb begin
        val_o = val_i;
        if (neg_i) val_o = neg_sat(val_i);
    end
endmodule

// File: rtl/cordic16_seq.sv
// Sequencer: folds the request angle into [-90,90), steps the core through
// load plus ITERS iterations, then captures and quadrant-corrects sin/cos.
module cordic16_seq import cordic_pkg::*; (
    input  logic           clock,
    input  logic           reset_n,
    cordic16_seq_if.slave  bus
);
    cordic_seq_state_t   state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                flip_q, flip_d;
    logic [W-1:0]        endangle_q, endangle_d;
    logic signed [W-1:0] sin_q, sin_d, cos_q, cos_d;
    logic signed [W-1:0] sin_fix, cos_fix;

    cordic_quadfix u_fix_sin (.neg_i(flip_q), .val_i(bus.core_sin), .val_o(sin_fix));
    cordic_quadfix u_fix_cos (.neg_i(flip_q), .val_i(bus.core_cos), .val_o(cos_fix));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            flip_q     <= 1'b0;
            endangle_q <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flip_q     <= flip_d;
            endangle_q <= endangle_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flip_d     = flip_q;
        endangle_d = endangle_q;
        sin_d      = sin_q;
        cos_d      = cos_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                // Angles in the 90..270 half differ from their fold by exactly 180 degrees.
                flip_d     = bus.in_angle[W-1] ^ bus.in_angle[W-2];
                endangle_d = bus.in_angle ^ (flip_d ? ANG_180 : '0);
                state_d    = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(ITERS - 1)) state_d = CAPT;
            end
            CAPT: begin
                sin_d   = sin_fix;
                cos_d   = cos_fix;
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.load      = (state_q == LOAD);
    assign bus.addr      = (state_q == ITER) ? cnt_q : '0;
    assign bus.endangle  = endangle_q;
    assign bus.out_sin   = sin_q;
    assign bus.out_cos   = cos_q;
endmodule

// File: tb/tb_cordic16_seq.sv
// Randomised scoreboard bench for cordic16_seq with an ideal trig core model.
module tb_cordic16_seq;
    import cordic_pkg::*;

    typedef struct {
        logic signed [15:0] s;
        logic signed [15:0] c;
        int                 tol;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    cordic16_seq_if bus();

    cordic16_seq dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    int   out_cyc_q[$];

    logic               core_ovr = 1'b0;
    logic signed [15:0] ovr_sin = '0;
    logic signed [15:0] ovr_cos = '0;
    logic signed [15:0] core_ang;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic signed [15:0] q14_sin(input int a);
        real r = 6.283185307179586 * real'(a) / 65536.0;
        return 16'($rtoi($floor($sin(r) * 16384.0 + 0.5)));
    endfunction

    function automatic logic signed [15:0] q14_cos(input int a);
        real r = 6.283185307179586 * real'(a) / 65536.0;
        return 16'($rtoi($floor($cos(r) * 16384.0 + 0.5)));
    endfunction

    // Ideal core: latches the reduced angle on load, answers with exact trig.
    always @(posedge clock or negedge reset_n)
        if (!reset_n) core_ang <= '0;
        else if (bus.load) core_ang <= bus.endangle;

    assign bus.core_sin = core_ovr ? ovr_sin : q14_sin(int'(core_ang));
    assign bus.core_cos = core_ovr ? ovr_cos : q14_cos(int'(core_ang));

    function automatic logic signed [15:0] neg_ref(input logic signed [15:0] v);
        int n = -int'(v);
        if (n > 32767) n = 32767;
        return 16'(n);
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic ovr,
                                   input logic signed [15:0] os, input logic signed [15:0] oc);
        exp_t m;
        bit fl = (a >= 16'h4000) && (a < 16'hC000);
        if (!ovr) begin
            m.s = q14_sin(int'(a));
            m.c = q14_cos(int'(a));
            m.tol = 4;
        end else begin
            m.s = fl ? neg_ref(os) : os;
            m.c = fl ? neg_ref(oc) : oc;
            m.tol = 0;
        end
        return m;
    endfunction

    function automatic logic [15:0] fold_ref(input logic [15:0] a);
        if (a >= 16'h4000 && a < 16'hC000) return 16'(int'(a) - 32768);
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic chkt(input string nm, input logic signed [15:0] act,
                        input logic signed [15:0] req, input int tol);
        int d = int'(act) - int'(req);
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (+-%0d)", nm, act, req, tol);
        end
    endtask

    // Accept monitor: pushes expectations and checks the folded angle.
    logic        ea_pend = 1'b0;
    logic [15:0] ea_exp;
    always @(negedge clock) begin
        if (ea_pend) begin
            chk("endangle", bus.endangle, ea_exp);
            ea_pend = 1'b0;
        end
        if (reset_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.in_angle, core_ovr, ovr_sin, ovr_cos));
            acc_q.push_back(cyc + 1);
            ea_exp  = fold_ref(bus.in_angle);
            ea_pend = 1'b1;
        end
    end

    // Output monitor: latency on rise, stability while stalled, data on transfer.
    logic               prev_ov = 1'b0;
    logic signed [15:0] hold_s, hold_c;
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.out_valid) begin
            if (!prev_ov) begin
                hold_s = bus.out_sin;
                hold_c = bus.out_cos;
                if (acc_q.size() == 0) chk("latency_noreq", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - acc_q.pop_front()), 32'd18);
            end else begin
                chk("hold_sin", bus.out_sin, hold_s);
                chk("hold_cos", bus.out_cos, hold_c);
            end
            if (bus.out_ready) begin
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chkt("out_sin", bus.out_sin, e.s, e.tol);
                    chkt("out_cos", bus.out_cos, e.c, e.tol);
                end
            end
        end
        prev_ov = reset_n && bus.out_valid;
    end

    task automatic send(input logic [15:0] a);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_angle = a;
        @(negedge clock);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 32'd1, 32'd0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_load"}, bus.load, 1'b0);
        chk({tag, "_addr"}, bus.addr, 4'd0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_endangle"}, bus.endangle, 16'h0000);
        chk({tag, "_out_sin"}, bus.out_sin, 16'h0000);
        chk({tag, "_out_cos"}, bus.out_cos, 16'h0000);
    endtask

    initial begin
        logic [15:0] sweep[4];
        int n;
        sweep[0] = 16'h0000; sweep[1] = 16'h2000; sweep[2] = 16'h4000; sweep[3] = 16'h8000;
        bus.in_valid = 1'b0;
        bus.in_angle = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        foreach (sweep[i]) begin
            send(sweep[i]);
            drain();
        end
        for (int i = 0; i < 20; i++) begin
            send(16'($urandom));
            drain();
        end

        // Core-interface trace for one request.
        send(16'h1555);
        for (int k = 0; k < 17; k++) begin
            @(negedge clock);
            chk("trace_load", bus.load, (k == 0) ? 1'b1 : 1'b0);
            chk("trace_addr", bus.addr, (k == 0) ? 4'd0 : 4'(k - 1));
            chk("trace_busy", bus.busy, 1'b1);
        end
        drain();

        // Backpressure in DONE with ignored request pulses.
        bus.out_ready = 1'b0;
        send(16'h1000);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("bp_valid", bus.out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1 bus.in_valid = i[0];
            bus.in_angle = 16'h3333;
            @(negedge clock);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_out_valid", bus.out_valid, 1'b1);
        end
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("bp_release_valid", bus.out_valid, 1'b0);
        chk("bp_release_ready", bus.in_ready, 1'b1);
        drain();

        // Asynchronous reset in the middle of the iteration phase.
        send(16'h1000);
        n = 0;
        while (bus.addr != 4'd7 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("rst_reach_addr7", bus.addr, 4'd7);
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("midrst");
        exp_q.delete();
        acc_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send(16'h0000);
        drain();

        // Saturating negate of the most negative core value.
        core_ovr = 1'b1;
        ovr_sin = 16'sh8000;
        ovr_cos = 16'sh1234;
        send(16'h8000);
        drain();
        send(16'h0000);
        drain();
        ovr_cos = 16'sh8000;
        ovr_sin = -16'sh0100;
        send(16'hA000);
        drain();
        core_ovr = 1'b0;

        // Back-to-back with both handshakes held high.
        out_cyc_q.delete();
        for (int i = 0; i < 5; i++) send(16'($urandom));
        drain();
        chk("b2b_count", 32'(out_cyc_q.size()), 32'd5);
        for (int i = 1; i < out_cyc_q.size(); i++)
            chk("b2b_spacing", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
